mac_dot_seq: RTL and testbench
==============================

Name: mac_dot_seq

Overview:
- Sequencer that computes a dot product Y = sum(A[i]*B[i]), i=0..len-1, on one shared combinational multiplier with sign select.
- Generates operand-memory read addresses, steers operands and the sign mode into the multiplier, and accumulates its products.
- Returns the sum through a valid/ready result handshake.
- Sits between the operand buffers and the result consumer; one job at a time.

Parameters:
N, 4, width of A operand
M, 4, width of B operand
AW, 4, address width; max vector length 2^AW
ACC_W, 12, accumulator/result width (must be >= N+M)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  job request, sampled in IDLE only
len  input  AW+1  vector length 0..2^AW, sampled with start
sg_in  input  1  1 = signed (two's complement), 0 = unsigned; sampled with start
busy  output  1  high from accepted start until result handshake completes
rd_en  output  1  operand read strobe
rd_addr  output  AW  operand read address
rd_a  input  N  A[rd_addr], valid exactly 1 cycle after rd_en
rd_b  input  M  B[rd_addr], valid exactly 1 cycle after rd_en
mul_a  output  N  multiplier operand A
mul_b  output  M  multiplier operand B
mul_sg  output  1  multiplier sign select
mul_y  input  N+M  combinational product of mul_a*mul_b
res  output  ACC_W  dot-product result
res_valid  output  1  result valid
res_ready  input  1  consumer accepts result

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, rd_en=0, rd_addr=0, mul_a=0, mul_b=0, mul_sg=0, res=0, res_valid=0; accumulator, counters and the pending-product flag cleared. A job in flight is abandoned; no partial result is ever presented.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on start=1 latch len and sg_in (as sg), clear the accumulator, set busy=1. If len=0, go to DONE with res=0. Otherwise go to RUN with rd_addr=0.
- RUN: rd_en=1 each cycle; rd_addr increments 0..len-1. After issuing address len-1, go to DRAIN.
- Read pipeline: the pending flag is the registered rd_en. While pending=1:
  - mul_a=rd_a, mul_b=rd_b, mul_sg=sg, all combinational pass-through.
  - At the clock edge, acc <= acc + ext(mul_y).
  - ext = sign-extend mul_y[N+M-1] when sg=1, zero-extend when sg=0.
- While pending=0, mul_a, mul_b and mul_sg are driven to 0.
- DRAIN: one cycle that consumes the last product. Then go to DONE with res=acc and res_valid=1.
- DONE: hold res and res_valid stable until res_ready=1. At that edge drop res_valid and busy and go to IDLE.
- Latency: the edge that accepts start is E0. For len=L≥1, res_valid rises after edge E0+L+1. For len=0, res_valid rises after E0.
- A new start is accepted no earlier than the cycle after the result handshake.
- start while busy=1 is ignored, not queued. start and res_ready arriving in the same DONE cycle: only the handshake takes effect.
- len and sg_in changes after acceptance have no effect on the running job.
- len=2^AW: rd_addr wraps from 2^AW-1 to 0 exactly once, at entry to DRAIN. No extra read is issued.
- Default arithmetic: the accumulator wraps modulo 2^ACC_W, with no overflow indication.

Optional Feature:
- Macro: MAC_DOT_SAT_EN.
- Defined:
  - Each accumulation saturates. When sg=1 the limits are 2^(ACC_W-1)-1 and -2^(ACC_W-1); when sg=0 the limit is 2^ACC_W-1.
  - Adds output port sat_flag (1 bit). It is set when any saturation occurs in the job, valid alongside res_valid, and cleared on start acceptance and on reset.
- Undefined: wrap-around arithmetic as above; no sat_flag port.

Test Plan:
- Unsigned, len=3, A={3,5,15}, B={2,4,15}, sg_in=0. Required: res=6+20+225=251. res_valid rises after E0+4. rd_addr sequence is 0,1,2.
- Signed, len=2, A={4'hD(-3),4'h7(7)}, B={4'h5(5),4'hE(-2)}, sg_in=1. Required: mul_sg=1 in both product cycles; res=-15-14=-29 (12'hFE3).
- len=0 with start. Required: no rd_en pulse; res_valid=1, res=0 after E0; busy drops on res_ready.
- Back-pressure: hold res_ready=0 for 5 cycles after res_valid, then pulse start twice. Required: res stable, busy=1, start ignored. After res_ready=1, busy=0 the next cycle; a subsequent start is accepted.
- Reset mid-job: len=16 all-ones, sg_in=0, assert rst at RUN cycle 7. Required: outputs immediately at reset values. A new job len=1, A=2, B=3 gives res=6.
- Full length/overflow: len=16, all A=B=15, sg_in=0. Expected sum 3600 (12'hE10), so no overflow. Repeat with ACC_W=10:
  - without MAC_DOT_SAT_EN: res=3600 mod 1024=528;
  - with MAC_DOT_SAT_EN: res=1023 and sat_flag=1.

Source files
------------

// File: rtl/mac_dot_seq.sv
// -----------------------------------------------------------------------------
// mac_dot_seq
//
// Purpose:
//   Dot-product sequencer. Reads operand pairs A[i], B[i] from an external
//   operand buffer (one-cycle read latency). It feeds them through one shared
//   external combinational multiplier that has a sign select. It accumulates
//   the products and returns Y = sum(A[i]*B[i]) over a valid/ready handshake.
//   Only one job is in flight at a time.
//
// Build option:
//   MAC_DOT_SAT_EN - when defined, each accumulation saturates to the signed
//                    or unsigned ACC_W range, and a sat_flag output reports
//                    whether any step of the job clipped. When undefined,
//                    the accumulator wraps modulo 2^ACC_W.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   start      job request, sampled in IDLE only
//   len        vector length 0..2^AW, sampled with start
//   sg_in      1 = signed operands, 0 = unsigned; sampled with start
//   busy       high from the accepted start until the result handshake
//   rd_en      operand read strobe
//   rd_addr    operand read address
//   rd_a/rd_b  operand data, valid one cycle after rd_en
//   mul_a/b    multiplier operands (zero when no product is pending)
//   mul_sg     multiplier sign select (zero when no product is pending)
//   mul_y      combinational product returned by the multiplier
//   res        dot-product result, held while res_valid is high
//   res_valid  result valid
//   res_ready  consumer accepts the result
//   sat_flag   (MAC_DOT_SAT_EN only) saturation occurred during the job
// -----------------------------------------------------------------------------
module mac_dot_seq #(
    parameter int N     = 4,
    parameter int M     = 4,
    parameter int AW    = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW:0]      len,
    input  logic             sg_in,
    output logic             busy,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr,
    input  logic [N-1:0]     rd_a,
    input  logic [M-1:0]     rd_b,
    output logic [N-1:0]     mul_a,
    output logic [M-1:0]     mul_b,
    output logic             mul_sg,
    input  logic [N+M-1:0]   mul_y,
    output logic [ACC_W-1:0] res,
    output logic             res_valid,
`ifdef MAC_DOT_SAT_EN
    output logic             sat_flag,
`endif
    input  logic             res_ready
);

    localparam int PW = N + M;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   LEN_ONE  = {{AW{1'b0}}, 1'b1};

    logic [1:0]       state_reg;
    logic [AW:0]      len_reg;
    logic             sg_reg;
    logic [AW-1:0]    addr_reg;
    logic             pending_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] res_reg;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] prod_ext;
    logic             last_addr;

    // Product widened to the accumulator width: the upper bits copy the
    // product MSB in signed mode and are zero in unsigned mode.
    genvar gi;
    generate
        for (gi = 0; gi < ACC_W; gi++) begin : g_ext
            if (gi < PW) begin : g_low
                assign prod_ext[gi] = mul_y[gi];
            end else begin : g_high
                assign prod_ext[gi] = sg_reg & mul_y[PW-1];
            end
        end
    endgenerate

`ifdef MAC_DOT_SAT_EN
    // Add in two extra bits so that an overflow can be detected in either
    // mode before the sum is clamped back into the ACC_W range.
    logic [ACC_W+1:0] acc_wide;
    logic [ACC_W+1:0] prod_wide;
    logic [ACC_W+1:0] sum_wide;
    logic             sat_hit;
    logic             sat_flag_reg;

    always_comb begin
        acc_wide  = {{2{sg_reg & acc_reg[ACC_W-1]}}, acc_reg};
        prod_wide = {{2{sg_reg & prod_ext[ACC_W-1]}}, prod_ext};
        sum_wide  = acc_wide + prod_wide;
        sat_hit   = 1'b0;
        acc_next  = sum_wide[ACC_W-1:0];
        if (sg_reg) begin
            // The top three bits disagree only when the sum is outside the
            // signed range. The sign bit shows which limit to clamp to.
            if (!((sum_wide[ACC_W+1:ACC_W-1] == 3'b000) ||
                  (sum_wide[ACC_W+1:ACC_W-1] == 3'b111))) begin
                sat_hit  = 1'b1;
                acc_next = sum_wide[ACC_W+1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                             : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            if (sum_wide[ACC_W+1:ACC_W] != 2'b00) begin
                sat_hit  = 1'b1;
                acc_next = {ACC_W{1'b1}};
            end
        end
    end

    assign sat_flag = sat_flag_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag_reg <= 1'b0;
        end else if (state_reg == S_IDLE && start) begin
            sat_flag_reg <= 1'b0;
        end else if (pending_reg && sat_hit) begin
            sat_flag_reg <= 1'b1;
        end
    end
`else
    assign acc_next = acc_reg + prod_ext;
`endif

    // len_reg is at least 1 whenever RUN is active, so len_reg-1 cannot
    // underflow. The compare uses AW+1 bits so that len = 2^AW works.
    assign last_addr = ({1'b0, addr_reg} == (len_reg - LEN_ONE));

    assign busy      = (state_reg != S_IDLE);
    assign rd_en     = (state_reg == S_RUN);
    assign rd_addr   = addr_reg;
    assign res       = res_reg;
    assign res_valid = (state_reg == S_DONE);

    // Operands reach the multiplier only while read data is valid.
    // At all other times they are zero.
    always_comb begin
        mul_a  = '0;
        mul_b  = '0;
        mul_sg = 1'b0;
        if (pending_reg) begin
            mul_a  = rd_a;
            mul_b  = rd_b;
            mul_sg = sg_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            len_reg     <= '0;
            sg_reg      <= 1'b0;
            addr_reg    <= '0;
            pending_reg <= 1'b0;
            acc_reg     <= '0;
            res_reg     <= '0;
        end else begin
            // A read issued this cycle returns data next cycle.
            pending_reg <= (state_reg == S_RUN);
            if (pending_reg) begin
                acc_reg <= acc_next;
            end

            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        len_reg  <= len;
                        sg_reg   <= sg_in;
                        acc_reg  <= '0;
                        addr_reg <= '0;
                        if (len == '0) begin
                            res_reg   <= '0;
                            state_reg <= S_DONE;
                        end else begin
                            state_reg <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // For a full-length job the address wraps to 0 on
                    // this final increment, as DRAIN is entered.
                    addr_reg <= addr_reg + ADDR_ONE;
                    if (last_addr) begin
                        state_reg <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The last product is still pending, so the result
                    // is taken from acc_next and includes that product.
                    res_reg   <= acc_next;
                    state_reg <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_seq.sv
module tb_mac_dot_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  len;
    logic        sg_in;
    logic        res_ready;

    // Default-width instance (ACC_W = 12)
    logic        busy, rd_en, mul_sg, res_valid;
    logic [3:0]  rd_addr, rd_a, rd_b, mul_a, mul_b;
    logic [7:0]  mul_y, prod_s, prod_u;
    logic [11:0] res;

    // Narrow instance (ACC_W = 10); it is checked on the overflow job only
    logic        busy10, rd_en10, mul_sg10, res_valid10;
    logic [3:0]  rd_addr10, rd_a10, rd_b10, mul_a10, mul_b10;
    logic [7:0]  mul_y10, prod_s10, prod_u10;
    logic [9:0]  res10;

`ifdef MAC_DOT_SAT_EN
    logic        sat_flag, sat_flag10;
`endif

    logic [3:0]  mem_a [16];
    logic [3:0]  mem_b [16];

    int tests_run;
    int tests_failed;
    int rd_cnt;
    int sg_cnt;
    int lat;
    int addr_log [20];

    mac_dot_seq #(.N(4), .M(4), .AW(4), .ACC_W(12)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .sg_in(sg_in),
        .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .rd_a(rd_a), .rd_b(rd_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_sg(mul_sg), .mul_y(mul_y),
        .res(res), .res_valid(res_valid),
`ifdef MAC_DOT_SAT_EN
        .sat_flag(sat_flag),
`endif
        .res_ready(res_ready)
    );

    mac_dot_seq #(.N(4), .M(4), .AW(4), .ACC_W(10)) dut10 (
        .clk(clk), .rst(rst), .start(start), .len(len), .sg_in(sg_in),
        .busy(busy10), .rd_en(rd_en10), .rd_addr(rd_addr10), .rd_a(rd_a10), .rd_b(rd_b10),
        .mul_a(mul_a10), .mul_b(mul_b10), .mul_sg(mul_sg10), .mul_y(mul_y10),
        .res(res10), .res_valid(res_valid10),
`ifdef MAC_DOT_SAT_EN
        .sat_flag(sat_flag10),
`endif
        .res_ready(res_ready)
    );

    // Multiplier models: signed or unsigned 4x4 -> 8-bit product
    assign prod_s   = $signed(mul_a) * $signed(mul_b);
    assign prod_u   = mul_a * mul_b;
    assign mul_y    = mul_sg ? prod_s : prod_u;
    assign prod_s10 = $signed(mul_a10) * $signed(mul_b10);
    assign prod_u10 = mul_a10 * mul_b10;
    assign mul_y10  = mul_sg10 ? prod_s10 : prod_u10;

    // Operand buffer models with one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) begin
            rd_a <= mem_a[rd_addr];
            rd_b <= mem_b[rd_addr];
        end
        if (rd_en10) begin
            rd_a10 <= mem_a[rd_addr10];
            rd_b10 <= mem_b[rd_addr10];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic load(input int idx, input logic [3:0] a, input logic [3:0] b);
        mem_a[idx] = a;
        mem_b[idx] = b;
    endtask

    task automatic start_job(input int l, input logic s);
        start = 1'b1;
        len   = l[4:0];
        sg_in = s;
        @(posedge clk);   // E0
        #1;
        start = 1'b0;
    endtask

    // Counts the edges after E0 until res_valid is seen. It logs the read
    // addresses and the cycles in which mul_sg is high.
    task automatic wait_result(output int n);
        n      = 0;
        rd_cnt = 0;
        sg_cnt = 0;
        while (!res_valid && n < 200) begin
            if (rd_en) begin
                if (rd_cnt < 20) addr_log[rd_cnt] = int'(rd_addr);
                rd_cnt++;
            end
            if (mul_sg) sg_cnt++;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        start        = 1'b0;
        len          = '0;
        sg_in        = 1'b0;
        res_ready    = 1'b0;
        for (int i = 0; i < 16; i++) load(i, 4'd0, 4'd0);

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_busy", busy, 0);
        check_eq("reset_rd_en", rd_en, 0);
        check_eq("reset_res_valid", res_valid, 0);
        check_eq("reset_res", res, 0);
        check_eq("reset_mul_a", mul_a, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Unsigned job, len=3: 6+20+225 = 251
        load(0, 4'd3, 4'd2);
        load(1, 4'd5, 4'd4);
        load(2, 4'd15, 4'd15);
        start_job(3, 1'b0);
        check_eq("u3_busy", busy, 1);
        wait_result(lat);
        check_eq("u3_latency", lat, 4);
        check_eq("u3_res", res, 251);
        check_eq("u3_rd_cnt", rd_cnt, 3);
        check_eq("u3_addr0", addr_log[0], 0);
        check_eq("u3_addr1", addr_log[1], 1);
        check_eq("u3_addr2", addr_log[2], 2);
        check_eq("u3_sg_cnt", sg_cnt, 0);
        handshake();
        check_eq("u3_busy_after", busy, 0);

        // Signed job, len=2: (-3*5)+(7*-2) = -29 = 12'hFE3
        load(0, 4'hD, 4'h5);
        load(1, 4'h7, 4'hE);
        start_job(2, 1'b1);
        wait_result(lat);
        check_eq("s2_latency", lat, 3);
        check_eq("s2_res", res, 12'hFE3);
        check_eq("s2_mul_sg_cycles", sg_cnt, 2);
`ifdef MAC_DOT_SAT_EN
        check_eq("s2_sat_flag", sat_flag, 0);
`endif
        handshake();

        // len=0: result immediately after E0, no read
        start_job(0, 1'b0);
        wait_result(lat);
        check_eq("z_latency", lat, 0);
        check_eq("z_res", res, 0);
        check_eq("z_rd_cnt", rd_cnt, 0);
        check_eq("z_rd_en", rd_en, 0);
        check_eq("z_busy", busy, 1);
        handshake();
        check_eq("z_busy_after", busy, 0);

        // Back-pressure: len=2, 1*3+2*4 = 11
        load(0, 4'd1, 4'd3);
        load(1, 4'd2, 4'd4);
        start_job(2, 1'b0);
        wait_result(lat);
        check_eq("bp_latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            start = (i == 1 || i == 3);
            len   = 5'd1;
            @(posedge clk);
            #1;
            start = 1'b0;
            check_eq($sformatf("bp_hold_res_%0d", i), res, 11);
            check_eq($sformatf("bp_hold_busy_%0d", i), busy, 1);
            check_eq($sformatf("bp_hold_valid_%0d", i), res_valid, 1);
        end
        // start and res_ready together: only the handshake takes effect
        start     = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        res_ready = 1'b0;
        check_eq("bp_busy_after", busy, 0);
        check_eq("bp_valid_after", res_valid, 0);
        @(posedge clk);
        #1;
        check_eq("bp_still_idle", busy, 0);
        start_job(1, 1'b0);
        wait_result(lat);
        check_eq("bp_next_latency", lat, 2);
        check_eq("bp_next_res", res, 3);
        handshake();

        // Reset mid-job at RUN cycle 7
        for (int i = 0; i < 16; i++) load(i, 4'd15, 4'd15);
        start_job(16, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rd_en", rd_en, 0);
        check_eq("rst_rd_addr", rd_addr, 0);
        check_eq("rst_mul_a", mul_a, 0);
        check_eq("rst_mul_sg", mul_sg, 0);
        check_eq("rst_res", res, 0);
        check_eq("rst_res_valid", res_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        load(0, 4'd2, 4'd3);
        start_job(1, 1'b0);
        wait_result(lat);
        check_eq("post_rst_latency", lat, 2);
        check_eq("post_rst_res", res, 6);
        handshake();

        // Full length: 16 * 225 = 3600; 3600 mod 1024 = 528
        for (int i = 0; i < 16; i++) load(i, 4'd15, 4'd15);
        start_job(16, 1'b0);
        wait_result(lat);
        check_eq("full_latency", lat, 17);
        check_eq("full_rd_cnt", rd_cnt, 16);
        check_eq("full_addr15", addr_log[15], 15);
        check_eq("full_rd_addr_wrapped", rd_addr, 0);
        check_eq("full_res12", res, 3600);
        check_eq("full_valid10", res_valid10, 1);
`ifdef MAC_DOT_SAT_EN
        check_eq("full_res10_sat", res10, 1023);
        check_eq("full_sat_flag10", sat_flag10, 1);
        check_eq("full_sat_flag12", sat_flag, 0);
`else
        check_eq("full_res10_wrap", res10, 528);
`endif
        handshake();
        check_eq("full_busy_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
